// File: rtl/irrigation_timer_countdown_if.sv
// irrigation_timer_countdown_if: command and status bundle between the timer and its controller
interface irrigation_timer_countdown_if #(parameter int REM_W = 5);
  logic [2:0] timer_code;
  logic start;
  logic stop;
  logic busy;
  logic [REM_W-1:0] remaining;
  logic done;
  logic code_err;
  modport master (output timer_code, start, stop, input busy, remaining, done, code_err);
  modport slave (input timer_code, start, stop, output busy, remaining, done, code_err);
endinterface

// File: rtl/irrigation_timer_countdown.sv
// irrigation_timer_countdown: decodes a duration code and counts it down in CLKS_PER_UNIT-clock units
module irrigation_timer_countdown #(
  parameter int CLKS_PER_UNIT = 50_000_000,
  parameter int REM_W = 5
) (
  input logic clk,
  input logic rst_n,
  irrigation_timer_countdown_if.slave bus
);
  localparam int PW = $clog2(CLKS_PER_UNIT);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [REM_W-1:0] rem, rem_n, dur;
  logic err, err_n, valid, wrap;
  always_comb begin
    valid = bus.timer_code <= 3'd4;
    dur = bus.timer_code == 3'd0 ? REM_W'(5) :
          bus.timer_code == 3'd1 ? REM_W'(10) :
          bus.timer_code == 3'd2 ? REM_W'(15) :
          bus.timer_code == 3'd3 ? REM_W'(22) : REM_W'(30);
    wrap = pre == PW'(CLKS_PER_UNIT - 1);
  end
  // stop beats start beats counting; a valid start restarts from any state
  always_comb begin
    state_n = state;
    pre_n = pre;
    rem_n = rem;
    err_n = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      pre_n = '0;
      rem_n = '0;
    end else if (bus.start && valid) begin
      state_n = RUN;
      pre_n = '0;
      rem_n = dur;
    end else begin
      err_n = bus.start;
      if (state == RUN) begin
        pre_n = wrap ? '0 : pre + 1'b1;
        rem_n = wrap ? rem - 1'b1 : rem;
        state_n = (wrap && rem == REM_W'(1)) ? DONE : RUN;
      end else if (state == DONE) begin
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      rem <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      pre <= pre_n;
      rem <= rem_n;
      err <= err_n;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.remaining = rem;
  assign bus.code_err = err;
endmodule

// File: tb/tb_irrigation_timer_countdown.sv
// tb_irrigation_timer_countdown: directed tests checked against an elapsed-time model every cycle
module tb_irrigation_timer_countdown;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int d = 0;
  bit act = 0;
  int e_rem = 0;
  bit e_busy = 0, e_done = 0, e_err = 0;
  int dur_tab[5] = '{5, 10, 15, 22, 30};
  irrigation_timer_countdown_if #(.REM_W(5)) bus ();
  irrigation_timer_countdown #(.CLKS_PER_UNIT(P), .REM_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // model: a countdown is just a start time and a duration; outputs follow from elapsed cycles
  always @(posedge clk) begin
    cyc++;
    e_done = 0;
    e_err = 0;
    if (!rst_n || bus.stop) act = 0;
    else begin
      if (bus.start && bus.timer_code > 3'd4) e_err = 1;
      if (bus.start && bus.timer_code <= 3'd4) begin
        act = 1;
        d = dur_tab[bus.timer_code];
        t0 = cyc;
      end else if (act && cyc - t0 == d * P) begin
        act = 0;
        e_done = 1;
      end
    end
    e_busy = act;
    e_rem = act ? d - (cyc - t0) / P : 0;
    #1;
    chk("busy", int'(bus.busy), int'(e_busy));
    chk("remaining", int'(bus.remaining), e_rem);
    chk("done", int'(bus.done), int'(e_done));
    chk("code_err", int'(bus.code_err), int'(e_err));
  end
  task automatic do_start(input logic [2:0] code, input logic stp, output int s);
    bus.start = 1'b1;
    bus.stop = stp;
    bus.timer_code = code;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    s = cyc;
  endtask
  task automatic wait_done(input string name, input int s, input int exp, input int max);
    for (int i = 0; i < max; i++) begin
      if (bus.done) begin
        chk(name, cyc - s, exp);
        chk({name, "_rem0"}, int'(bus.remaining), 0);
        @(negedge clk);
        chk({name, "_after_done"}, int'(bus.done), 0);
        chk({name, "_after_busy"}, int'(bus.busy), 0);
        return;
      end
      @(negedge clk);
    end
    chk({name, "_timeout"}, 1, 0);
  endtask
  task automatic wait_rem(input string name, input int target, input int max);
    for (int i = 0; i < max; i++) begin
      if (int'(bus.remaining) == target) return;
      @(negedge clk);
    end
    chk({name, "_timeout"}, int'(bus.remaining), target);
  endtask
  initial begin
    int s;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.timer_code = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_rem", int'(bus.remaining), 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(3'd0, 1'b0, s);
    chk("t1_load", int'(bus.remaining), 5);
    repeat (P) @(negedge clk);
    chk("t1_first_dec", int'(bus.remaining), 4);
    wait_done("t1_done_lat", s, 20, 40);
    do_start(3'd4, 1'b0, s);
    chk("t2_load", int'(bus.remaining), 30);
    wait_done("t2_done_lat", s, 120, 200);
    do_start(3'd5, 1'b0, s);
    chk("t3_err5", int'(bus.code_err), 1);
    chk("t3_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("t3_err_pulse", int'(bus.code_err), 0);
    do_start(3'd7, 1'b0, s);
    chk("t3_err7", int'(bus.code_err), 1);
    chk("t3_rem", int'(bus.remaining), 0);
    do_start(3'd3, 1'b0, s);
    chk("t4_load", int'(bus.remaining), 22);
    wait_rem("t4_reach2", 2, 120);
    do_start(3'd1, 1'b0, s);
    chk("t4_reload", int'(bus.remaining), 10);
    wait_done("t4_done_lat", s, 40, 80);
    do_start(3'd4, 1'b0, s);
    repeat (10) @(negedge clk);
    do_start(3'd6, 1'b0, s);
    chk("run_bad_err", int'(bus.code_err), 1);
    chk("run_bad_busy", int'(bus.busy), 1);
    repeat (3) @(negedge clk);
    do_start(3'd2, 1'b1, s);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_rem", int'(bus.remaining), 0);
    chk("t5_err", int'(bus.code_err), 0);
    repeat (3) @(negedge clk);
    do_start(3'd3, 1'b0, s);
    wait_rem("t6_reach7", 7, 120);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_rem", int'(bus.remaining), 0);
    chk("t6_rst_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(3'd0, 1'b0, s);
    chk("t6_load", int'(bus.remaining), 5);
    wait_done("t6_done_lat", s, 20, 40);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
